uart_cmd_rx: RTL and testbench

Receive side of the console UART. Deserialises 8N1 bytes from the host line, checks framing, and parses short ASCII command lines into one-cycle action pulses for the pet state logic (feed, play, clean, sleep and so on). It sits beside the status-dump transmitter. Its outputs drive the need counters directly, in place of the push-button actions.

---
 rtl/uart_cmd_rx.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// Console UART receiver: 8N1 deserialiser plus ASCII command-line parser.
// Emits one-cycle action pulses (code + argument) for the pet state logic.
module uart_cmd_rx #(
  parameter int DELAY_FRAMES = 234,
  parameter int CMD_TIMEOUT  = 27000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [3:0] cmd_arg,
  output logic       cmd_err
);

  localparam int CW = $clog2(DELAY_FRAMES + 1);
  localparam int TW = $clog2(CMD_TIMEOUT + 1);
  localparam logic [CW-1:0] HALF = CW'(DELAY_FRAMES / 2);
  localparam logic [CW-1:0] LAST = CW'(DELAY_FRAMES - 1);
  localparam logic [TW-1:0] TMAX = TW'(CMD_TIMEOUT);

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_STOP, R_BREAK
  } rstate_t;

  typedef enum logic [1:0] {
    P_IDLE, P_CMD, P_ARG, P_DISCARD
  } pstate_t;

  rstate_t rstate;
  pstate_t pstate;

  logic          sync1, sync2, line;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [TW-1:0] tcnt;
  logic [2:0]    pcode;
  logic [3:0]    parg;
  logic          frame_hit;

  function automatic logic is_term(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) ||
           (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] b);
    logic [7:0] t;
    if (b <= 8'h39)      t = b - 8'h30;
    else if (b <= 8'h46) t = b - 8'h37;
    else                 t = b - 8'h57;
    return t[3:0];
  endfunction

  function automatic logic is_cmd(input logic [7:0] b);
    logic [7:0] u;
    u = (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
    return (u == 8'h46) || (u == 8'h50) || (u == 8'h43) ||
           (u == 8'h53) || (u == 8'h4D) || (u == 8'h54) ||
           (u == 8'h3F);
  endfunction

  function automatic logic [2:0] cmd_val(input logic [7:0] b);
    logic [7:0] u;
    logic [2:0] c;
    u = (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
    case (u)
      8'h46:   c = 3'd0;
      8'h50:   c = 3'd1;
      8'h43:   c = 3'd2;
      8'h53:   c = 3'd3;
      8'h4D:   c = 3'd4;
      8'h54:   c = 3'd5;
      default: c = 3'd6;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      sync2 <= sync1;
    end
  end

  assign line = sync2;

  // Stop bit sampled low; the parser reacts in this same cycle.
  assign frame_hit = (rstate == R_STOP) && (cnt == LAST) && !line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate        <= R_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
      case (rstate)
        R_IDLE: begin
          if (!line) begin
            rstate <= R_START;
            cnt    <= '0;
          end
        end
        R_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            rstate  <= line ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        R_DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            shreg   <= {line, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rstate <= R_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        R_STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (line) begin
              rx_byte       <= shreg;
              rx_byte_valid <= 1'b1;
              rstate        <= R_IDLE;
            end else begin
              frame_err <= 1'b1;
              rstate    <= R_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        R_BREAK: begin
          if (line) rstate <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate    <= P_IDLE;
      tcnt      <= '0;
      pcode     <= '0;
      parg      <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_arg   <= '0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      if (frame_hit) begin
        cmd_err <= (pstate != P_DISCARD);
        pstate  <= P_DISCARD;
        tcnt    <= '0;
      end else if (rx_byte_valid) begin
        tcnt <= '0;
        case (pstate)
          P_IDLE: begin
            if (is_cmd(rx_byte)) begin
              pcode  <= cmd_val(rx_byte);
              parg   <= 4'd1;
              pstate <= P_CMD;
            end else if (!is_term(rx_byte)) begin
              cmd_err <= 1'b1;
              pstate  <= P_DISCARD;
            end
          end
          P_CMD: begin
            if (is_hex(rx_byte)) begin
              parg   <= hex_val(rx_byte);
              pstate <= P_ARG;
            end else if (is_term(rx_byte)) begin
              cmd_valid <= 1'b1;
              cmd_code  <= pcode;
              cmd_arg   <= parg;
              pstate    <= P_IDLE;
            end else begin
              cmd_err <= 1'b1;
              pstate  <= P_DISCARD;
            end
          end
          P_ARG: begin
            if (is_term(rx_byte)) begin
              cmd_valid <= 1'b1;
              cmd_code  <= pcode;
              cmd_arg   <= parg;
              pstate    <= P_IDLE;
            end else begin
              cmd_err <= 1'b1;
              pstate  <= P_DISCARD;
            end
          end
          default: begin
            if (is_term(rx_byte)) pstate <= P_IDLE;
          end
        endcase
      end else if (pstate == P_CMD || pstate == P_ARG) begin
        if (tcnt == TMAX) begin
          tcnt   <= '0;
          pstate <= P_IDLE;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: table of command lines plus
// hand-written framing, glitch, timeout and reset sequences.
module tb_uart_cmd_rx;

  localparam int DF = 8;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       frame_err;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [3:0] cmd_arg;
  logic       cmd_err;

  uart_cmd_rx #(.DELAY_FRAMES(DF), .CMD_TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .uart_rx(uart_rx),
    .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .frame_err(frame_err),
    .cmd_valid(cmd_valid),
    .cmd_code(cmd_code),
    .cmd_arg(cmd_arg),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          n;
    int          cv;
    logic [2:0]  code;
    logic [3:0]  arg;
    int          ce;
  } vec_t;

  vec_t tv[12];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_rx_cyc = 0;
  int n_rx, n_fe, n_ce, n_cv, n_fe_ce;
  int n_both = 0;
  logic [7:0] last_rx;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rx_byte_valid) begin
      n_rx++;
      last_rx = rx_byte;
      last_rx_cyc = cyc;
    end
    if (frame_err) n_fe++;
    if (cmd_err) n_ce++;
    if (frame_err && cmd_err) n_fe_ce++;
    if (cmd_valid && cmd_err) n_both++;
    if (cmd_valid) begin
      n_cv++;
      check("cv_latency", cyc - last_rx_cyc, 1);
    end
  end

  task automatic clr();
    n_rx = 0;
    n_fe = 0;
    n_ce = 0;
    n_cv = 0;
    n_fe_ce = 0;
    last_rx = 8'h00;
  endtask

  task automatic hold(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    hold(1'b0, DF);
    for (int i = 0; i < 8; i++) hold(b[i], DF);
    hold(stop, DF);
  endtask

  task automatic send_str(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) send_byte(d[8*i +: 8], 1'b1);
  endtask

  function automatic vec_t mk(input logic [31:0] d, input int n,
                              input int cv, input logic [2:0] c,
                              input logic [3:0] a, input int ce);
    vec_t v;
    v.data = d;
    v.n = n;
    v.cv = cv;
    v.code = c;
    v.arg = a;
    v.ce = ce;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = mk(32'h00000D46, 2, 1, 3'd0, 4'd1,  0);
    tv[1]  = mk(32'h000A3763, 3, 1, 3'd2, 4'd7,  0);
    tv[2]  = mk(32'h000D4343, 3, 1, 3'd2, 4'd12, 0);
    tv[3]  = mk(32'h00000D58, 2, 0, 3'd2, 4'd12, 1);
    tv[4]  = mk(32'h00000D53, 2, 1, 3'd3, 4'd1,  0);
    tv[5]  = mk(32'h000A0D6D, 3, 1, 3'd4, 4'd1,  0);
    tv[6]  = mk(32'h000D3574, 3, 1, 3'd5, 4'd5,  0);
    tv[7]  = mk(32'h000A613F, 3, 1, 3'd6, 4'd10, 0);
    tv[8]  = mk(32'h0D783146, 4, 0, 3'd6, 4'd10, 1);
    tv[9]  = mk(32'h0000000D, 1, 0, 3'd6, 4'd10, 0);
    tv[10] = mk(32'h000D6746, 3, 0, 3'd6, 4'd10, 1);
    tv[11] = mk(32'h000D4670, 3, 1, 3'd1, 4'd15, 0);

    clr();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {rx_byte, rx_byte_valid, frame_err, cmd_valid,
           cmd_code, cmd_arg, cmd_err}, 0);
    rst = 1'b0;
    hold(1'b1, 10);

    for (int k = 0; k < 12; k++) begin
      clr();
      send_str(tv[k].data, tv[k].n);
      hold(1'b1, 16);
      check($sformatf("v%0d_rx_count", k), n_rx, tv[k].n);
      check($sformatf("v%0d_last_byte", k), last_rx,
            tv[k].data[8*(tv[k].n-1) +: 8]);
      check($sformatf("v%0d_cmd_valid", k), n_cv, tv[k].cv);
      check($sformatf("v%0d_cmd_err", k), n_ce, tv[k].ce);
      check($sformatf("v%0d_cmd_code", k), cmd_code, tv[k].code);
      check($sformatf("v%0d_cmd_arg", k), cmd_arg, tv[k].arg);
    end

    clr();
    hold(1'b0, 2);
    hold(1'b1, 40);
    check("glitch_rx", n_rx, 0);
    check("glitch_fe", n_fe, 0);
    send_str(32'h00000D46, 2);
    hold(1'b1, 16);
    check("glitch_after_rx", n_rx, 2);
    check("glitch_after_cv", n_cv, 1);
    check("glitch_after_code", cmd_code, 0);

    clr();
    send_byte(8'h55, 1'b0);
    hold(1'b0, 40 * DF);
    hold(1'b1, 2 * DF);
    check("break_fe", n_fe, 1);
    check("break_rx", n_rx, 0);
    check("break_ce", n_ce, 1);
    check("break_fe_ce_same", n_fe_ce, 1);
    check("break_rx_byte_kept", rx_byte, 8'h0D);
    clr();
    send_str(32'h00000D3F, 2);
    hold(1'b1, 16);
    check("discard_cv", n_cv, 0);
    check("discard_ce", n_ce, 0);
    clr();
    send_str(32'h00000D3F, 2);
    hold(1'b1, 16);
    check("status_cv", n_cv, 1);
    check("status_code", cmd_code, 6);
    check("status_arg", cmd_arg, 1);

    clr();
    send_byte(8'h50, 1'b1);
    hold(1'b1, 120);
    send_byte(8'h0D, 1'b1);
    hold(1'b1, 16);
    check("timeout_rx", n_rx, 2);
    check("timeout_cv", n_cv, 0);
    check("timeout_ce", n_ce, 0);
    check("timeout_code_held", cmd_code, 6);

    clr();
    fork
      send_str(32'h00000D54, 2);
      begin
        repeat (40) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midbyte_reset",
              {rx_byte, rx_byte_valid, frame_err, cmd_valid,
               cmd_code, cmd_arg, cmd_err}, 0);
      end
    join
    hold(1'b1, 4);
    rst = 1'b0;
    hold(1'b1, 20);
    clr();
    send_str(32'h00000D54, 2);
    hold(1'b1, 16);
    check("talk_cv", n_cv, 1);
    check("talk_code", cmd_code, 5);
    check("talk_arg", cmd_arg, 1);
    check("talk_ce", n_ce, 0);

    check("never_valid_and_err", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
